cache_control_nway: RTL and testbench

Parametrised control unit for the N-way, write-back, write-allocate L1 cache. It sits between the cache datapath (tag/valid/dirty/data arrays, per-way comparators) and the physical-memory port. It owns per-set tree pseudo-LRU state, victim selection and the miss/writeback sequencing. It supersedes the fixed-associativity controller, with configurable way count, tree-PLRU replacement, and invalid-way-first allocation.

---
 rtl/cache_control_nway_pkg.sv | 42 ++++
 rtl/cache_control_nway_plru_tree.sv | 47 ++++
 rtl/cache_control_nway.sv | 141 ++++++++++++++
 tb/tb_cache_control_nway.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_control_nway_pkg.sv
// Shared types and tree-PLRU helpers for the N-way cache controller.
package cache_control_nway_pkg;

  localparam int WAYS_DEF = 4;
  localparam int SETS_DEF = 8;
  localparam int MAX_WAYS = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FILL      = 2'd2
  } state_e;

  // Heap-ordered tree: node n has children 2n+1 (lower ways) and 2n+2 (upper ways).
  function automatic int plru_victim(input logic [MAX_WAYS-2:0] bits, input int ways);
    int node;
    node = 0;
    for (int l = 0; l < 3; l++) begin
      if ((1 << l) < ways) node = 2 * node + 1 + int'(bits[3'(node)]);
    end
    return node - (ways - 1);
  endfunction

  // Walk from the accessed leaf up to the root, pointing each node at the other half.
  function automatic logic [MAX_WAYS-2:0] plru_update(input logic [MAX_WAYS-2:0] bits,
                                                      input int way, input int ways);
    logic [MAX_WAYS-2:0] upd;
    int node;
    int parent;
    upd  = bits;
    node = way + ways - 1;
    for (int l = 0; l < 3; l++) begin
      if (node != 0) begin
        parent            = (node - 1) / 2;
        upd[3'(parent)]   = node[0];
        node              = parent;
      end
    end
    return upd;
  endfunction

endpackage

// File: rtl/cache_control_nway_plru_tree.sv
// Per-set tree pseudo-LRU state with victim lookup and access update.
module plru_tree
  import cache_control_nway_pkg::*;
#(
  parameter int WAYS  = WAYS_DEF,
  parameter int SETS  = SETS_DEF,
  parameter int IDX_W = $clog2(SETS),
  parameter int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_index,
  output logic [WAY_W-1:0] victim,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_index,
  input  logic [WAYS-1:0]  upd_way
);

  typedef logic [WAYS-2:0] node_t;

  node_t               bits_q [SETS];
  logic [MAX_WAYS-2:0] rd_bits;
  logic [MAX_WAYS-2:0] upd_bits;
  int                  upd_idx;

  always_comb begin
    rd_bits              = '0;
    rd_bits[WAYS-2:0]    = bits_q[rd_index];
    upd_bits             = '0;
    upd_bits[WAYS-2:0]   = bits_q[upd_index];
    upd_idx              = 0;
    for (int w = 0; w < WAYS; w++) begin
      if (upd_way[w]) upd_idx = w;
    end
  end

  assign victim = WAY_W'(plru_victim(rd_bits, WAYS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) bits_q[s] <= '0;
    end else if (upd_en) begin
      bits_q[upd_index] <= node_t'(plru_update(upd_bits, upd_idx, WAYS));
    end
  end

endmodule

// File: rtl/cache_control_nway.sv
// N-way write-back / write-allocate L1 cache controller: hit handling, victim
// selection (invalid-first, then tree PLRU) and writeback/fill sequencing.
module cache_control_nway
  import cache_control_nway_pkg::*;
#(
  parameter int WAYS  = WAYS_DEF,
  parameter int SETS  = SETS_DEF,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [IDX_W-1:0] index,
  input  logic [WAYS-1:0]  hit_vec,
  input  logic [WAYS-1:0]  valid_vec,
  input  logic [WAYS-1:0]  dirty_vec,
  input  logic             pmem_resp,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic             pmem_addr_sel,
  output logic [WAYS-1:0]  way_sel,
  output logic             data_load,
  output logic             tag_load,
  output logic             valid_load,
  output logic             dirty_load,
  output logic             data_src_sel,
  output logic             dirty_in
);

  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_e           state_q, state_d;
  logic [WAYS-1:0]  victim_q;
  logic             req, hit;
  logic             any_inv;
  logic [WAY_W-1:0] inv_idx, plru_idx, victim_idx;
  logic [WAYS-1:0]  victim_oh;
  logic             victim_dirty;

  plru_tree #(
    .WAYS  (WAYS),
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .WAY_W (WAY_W)
  ) u_plru (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (index),
    .victim    (plru_idx),
    .upd_en    (mem_resp),
    .upd_index (index),
    .upd_way   (hit_vec)
  );

  assign req = mem_read | mem_write;
  assign hit = |hit_vec;

  // Lowest-index invalid way wins over the PLRU choice.
  always_comb begin
    any_inv = 1'b0;
    inv_idx = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_vec[w]) begin
        any_inv = 1'b1;
        inv_idx = WAY_W'(w);
      end
    end
  end

  assign victim_idx   = any_inv ? inv_idx : plru_idx;
  assign victim_oh    = WAYS'(1) << victim_idx;
  assign victim_dirty = valid_vec[victim_idx] & dirty_vec[victim_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      victim_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req && !hit) victim_q <= victim_oh;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (req && !hit) state_d = victim_dirty ? ST_WRITEBACK : ST_FILL;
      ST_WRITEBACK: if (pmem_resp) state_d = ST_FILL;
      ST_FILL:      if (pmem_resp) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    way_sel       = '0;
    data_load     = 1'b0;
    tag_load      = 1'b0;
    valid_load    = 1'b0;
    dirty_load    = 1'b0;
    data_src_sel  = 1'b0;
    dirty_in      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req && hit) begin
          mem_resp = 1'b1;
          way_sel  = hit_vec;
          if (mem_write) begin
            data_load    = 1'b1;
            data_src_sel = 1'b1;
            dirty_load   = 1'b1;
            dirty_in     = 1'b1;
          end
        end
      end
      ST_WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        way_sel       = victim_q;
      end
      ST_FILL: begin
        pmem_read = 1'b1;
        way_sel   = victim_q;
        // Line lands only on the completion cycle; the retry then hits as clean.
        if (pmem_resp) begin
          data_load  = 1'b1;
          tag_load   = 1'b1;
          valid_load = 1'b1;
          dirty_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_control_nway.sv
// Directed plus randomized bench for cache_control_nway with a tag-array
// environment and a range-based tree-PLRU reference model.
module tb_cache_control_nway;

  localparam int WAYS  = 4;
  localparam int SETS  = 8;
  localparam int IDX_W = 3;
  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             mem_read, mem_write;
  logic [IDX_W-1:0] index;
  logic [WAYS-1:0]  hit_vec, valid_vec, dirty_vec;
  logic             pmem_resp;
  logic             mem_resp, pmem_read, pmem_write, pmem_addr_sel;
  logic [WAYS-1:0]  way_sel;
  logic             data_load, tag_load, valid_load, dirty_load, data_src_sel, dirty_in;

  always #5 clk = ~clk;

  cache_control_nway #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .index         (index),
    .hit_vec       (hit_vec),
    .valid_vec     (valid_vec),
    .dirty_vec     (dirty_vec),
    .pmem_resp     (pmem_resp),
    .mem_resp      (mem_resp),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_addr_sel (pmem_addr_sel),
    .way_sel       (way_sel),
    .data_load     (data_load),
    .tag_load      (tag_load),
    .valid_load    (valid_load),
    .dirty_load    (dirty_load),
    .data_src_sel  (data_src_sel),
    .dirty_in      (dirty_in)
  );

  // [13] mem_resp [12] pmem_read [11] pmem_write [10] addr_sel [9:6] way_sel
  // [5] data_load [4] tag_load [3] valid_load [2] dirty_load [1] data_src_sel [0] dirty_in
  logic [13:0] obs_vec;
  assign obs_vec = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel,
                    data_load, tag_load, valid_load, dirty_load, data_src_sel, dirty_in};

  // Datapath environment (driven by DUT strobes) and independent reference model.
  logic [TAG_W-1:0] env_tag [SETS][WAYS];
  bit               env_valid [SETS][WAYS];
  bit               env_dirty [SETS][WAYS];
  logic [TAG_W-1:0] m_tag [SETS][WAYS];
  bit               m_valid [SETS][WAYS];
  bit               m_dirty [SETS][WAYS];
  bit               m_plru [SETS][WAYS-1];

  logic [TAG_W-1:0] cur_tag;
  logic [13:0]      cap_vec;
  logic [IDX_W-1:0] cap_idx;
  logic [TAG_W-1:0] cap_tag;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] mk(input bit resp, input bit rd, input bit wr, input bit asel,
                                     input logic [WAYS-1:0] ws, input bit dl, input bit tl,
                                     input bit vl, input bit dyl, input bit dsrc, input bit din);
    return {resp, rd, wr, asel, ws, dl, tl, vl, dyl, dsrc, din};
  endfunction

  // Tree walked by way ranges: node bit 0 means "victim lies in the lower half".
  function automatic int m_victim(input int s);
    int lo, hi, n, mid;
    lo = 0; hi = WAYS; n = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (m_plru[s][n] == 1'b0) begin hi = mid; n = 2 * n + 1; end
      else begin lo = mid; n = 2 * n + 2; end
    end
    return lo;
  endfunction

  task automatic m_touch(input int s, input int w);
    int lo, hi, n, mid;
    lo = 0; hi = WAYS; n = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w < mid) begin m_plru[s][n] = 1'b1; hi = mid; n = 2 * n + 1; end
      else begin m_plru[s][n] = 1'b0; lo = mid; n = 2 * n + 2; end
    end
  endtask

  task automatic m_clear_plru();
    for (int s = 0; s < SETS; s++)
      for (int n = 0; n < WAYS - 1; n++) m_plru[s][n] = 1'b0;
  endtask

  task automatic refresh();
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w]   = env_valid[index][w] && (env_tag[index][w] == cur_tag);
      valid_vec[w] = env_valid[index][w];
      dirty_vec[w] = env_dirty[index][w];
    end
  endtask

  task automatic preload(input int s, input int w, input logic [TAG_W-1:0] t, input bit v, input bit d);
    env_tag[s][w] = t; env_valid[s][w] = v; env_dirty[s][w] = d;
    m_tag[s][w]   = t; m_valid[s][w]   = v; m_dirty[s][w]   = d;
  endtask

  // One clock: inputs already set; check mid-cycle, then apply array writes at the edge.
  task automatic cycle(input string tag, input logic [13:0] exp);
    refresh();
    @(negedge clk);
    chk("hit_onehot", 32'($onehot0(hit_vec)), 32'd1);
    chk(tag, 32'(obs_vec), 32'(exp));
    cap_vec = obs_vec; cap_idx = index; cap_tag = cur_tag;
    @(posedge clk);
    for (int w = 0; w < WAYS; w++) begin
      if (cap_vec[6 + w]) begin
        if (cap_vec[4]) env_tag[cap_idx][w] = cap_tag;
        if (cap_vec[3]) env_valid[cap_idx][w] = 1'b1;
        if (cap_vec[2]) env_dirty[cap_idx][w] = cap_vec[0];
      end
    end
    #1;
  endtask

  task automatic check_set(input int s);
    for (int w = 0; w < WAYS; w++) begin
      chk("arr_valid", 32'(env_valid[s][w]), 32'(m_valid[s][w]));
      chk("arr_dirty", 32'(env_dirty[s][w] & m_valid[s][w]), 32'(m_dirty[s][w] & m_valid[s][w]));
      if (m_valid[s][w]) chk("arr_tag", 32'(env_tag[s][w]), 32'(m_tag[s][w]));
    end
  endtask

  task automatic do_req(input int s, input logic [TAG_W-1:0] tg, input bit wr, input int wb_n, input int fill_n);
    int hw, v;
    bit dirty;
    logic [WAYS-1:0] oh;
    cur_tag = tg; index = IDX_W'(s);
    mem_read = !wr; mem_write = wr; pmem_resp = 1'b0;
    hw = -1;
    for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == tg) hw = w;
    if (hw < 0) begin
      v = -1;
      for (int w = 0; w < WAYS; w++) if (v < 0 && !m_valid[s][w]) v = w;
      if (v < 0) v = m_victim(s);
      dirty = m_valid[s][v] && m_dirty[s][v];
      oh = WAYS'(1) << v;
      cycle("miss_cycle", '0);
      if (dirty) begin
        for (int i = 1; i <= wb_n; i++) begin
          pmem_resp = (i == wb_n);
          cycle("writeback", mk(0, 0, 1, 1, oh, 0, 0, 0, 0, 0, 0));
        end
      end
      for (int i = 1; i <= fill_n; i++) begin
        pmem_resp = (i == fill_n);
        cycle("fill", mk(0, 1, 0, 0, oh, i == fill_n, i == fill_n, i == fill_n, i == fill_n, 0, 0));
      end
      pmem_resp = 1'b0;
      m_tag[s][v] = tg; m_valid[s][v] = 1'b1; m_dirty[s][v] = 1'b0;
      hw = v;
    end
    cycle(wr ? "write_hit" : "read_hit", mk(1, 0, 0, 0, WAYS'(1) << hw, wr, 0, 0, wr, wr, wr));
    m_touch(s, hw);
    if (wr) m_dirty[s][hw] = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0;
    check_set(s);
  endtask

  task automatic idle_cycle();
    mem_read = 1'b0; mem_write = 1'b0;
    pmem_resp = 1'($urandom_range(0, 1));
    cycle("idle", '0);
    pmem_resp = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; index = '0;
    pmem_resp = 1'b0; cur_tag = '0;
    hit_vec = '0; valid_vec = '0; dirty_vec = '0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) preload(s, w, '0, 1'b0, 1'b0);
    m_clear_plru();

    #2;
    chk("reset_outputs", 32'(obs_vec), 32'd0);
    @(negedge clk);
    chk("reset_outputs_held", 32'(obs_vec), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    idle_cycle();

    // Set 3 fully valid: read hit way 2, then write hit way 1.
    for (int w = 0; w < WAYS; w++) preload(3, w, TAG_W'(8'h10 + w), 1'b1, 1'b0);
    do_req(3, 8'h12, 1'b0, 1, 1);
    do_req(3, 8'h11, 1'b1, 1, 1);
    idle_cycle();

    // Clean miss into invalid way 1 of set 2, fill completes on 5th cycle.
    for (int w = 0; w < WAYS; w++) preload(2, w, TAG_W'(8'h20 + w), w != 1, 1'b0);
    do_req(2, 8'h2f, 1'b0, 1, 5);

    // Dirty miss on set 5: fresh PLRU victim way 0 is dirty; wb 4, fill 5.
    for (int w = 0; w < WAYS; w++) preload(5, w, TAG_W'(8'h50 + w), 1'b1, w == 0);
    do_req(5, 8'h5f, 1'b1, 4, 5);
    idle_cycle();

    // Sequential reads to every way of set 6, then a miss evicts way 0.
    for (int w = 0; w < WAYS; w++) preload(6, w, TAG_W'(8'h60 + w), 1'b1, 1'b0);
    for (int w = 0; w < WAYS; w++) do_req(6, TAG_W'(8'h60 + w), 1'b0, 1, 1);
    do_req(6, 8'h6f, 1'b0, 1, 3);

    // Reset in FILL cycle 2: pmem_read drops at once, PLRU clears, no array writes.
    cur_tag = 8'h77; index = 3'd1; mem_read = 1'b1; mem_write = 1'b0; pmem_resp = 1'b0;
    cycle("rst_miss", '0);
    cycle("rst_fill1", mk(0, 1, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 0));
    #1 rst = 1'b1;
    #1;
    chk("rst_async_outputs", 32'(obs_vec), 32'd0);
    mem_read = 1'b0;
    @(negedge clk);
    chk("rst_hold_outputs", 32'(obs_vec), 32'd0);
    rst = 1'b0;
    m_clear_plru();
    @(posedge clk); #1;
    check_set(1);
    idle_cycle();
    // Cleared PLRU on a full set 6 picks way 0 again.
    do_req(6, 8'h6e, 1'b0, 1, 2);

    // Randomized traffic over a small tag pool to force hits, clean and dirty evictions.
    for (int t = 0; t < 200; t++) begin
      do_req(int'($urandom_range(0, SETS - 1)), TAG_W'($urandom_range(0, 6)),
             1'($urandom_range(0, 1)), int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
